// File: rtl/sig_pkg.sv
// Shared definitions for the signal generator and its increment-recovery monitor.
package sig_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        ACQ    = 2'd2,
        LOCKED = 2'd3
    } state_t;

    // The counter and the monitor must agree on this width.
    localparam int SIG_WIDTH      = 8;
    localparam int SIG_LOCK_COUNT = 4;

endpackage

// File: rtl/incr_recover.sv
// Recovers the per-step increment of an observed modular counter and reports
// lock, step changes (mismatch) and wrap-around.
module incr_recover
    import sig_pkg::*;
#(
    parameter int WIDTH      = SIG_WIDTH,
    parameter int LOCK_COUNT = SIG_LOCK_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] incr_out,
    output logic             locked,
    output logic             mismatch,
    output logic             wrap,
    output state_t           state_dbg
);

    localparam int CW = $clog2(LOCK_COUNT + 1);

    // valid is a one-way strobe with no backpressure: every cycle with
    // valid=1 and clear=0 accepts exactly one count sample.

    state_t           state, state_d;
    logic [WIDTH-1:0] prev, prev_d;
    logic [WIDTH-1:0] cand, cand_d;
    logic [WIDTH-1:0] incr_d;
    logic [WIDTH-1:0] delta;
    logic [CW-1:0]    match_cnt, match_cnt_d, match_inc;
    logic             locked_d, mismatch_d, wrap_d;

    assign delta     = count - prev;
    assign match_inc = match_cnt + CW'(1);
    assign state_dbg = state;

    always_comb begin
        state_d     = state;
        prev_d      = prev;
        cand_d      = cand;
        match_cnt_d = match_cnt;
        incr_d      = incr_out;
        locked_d    = locked;
        mismatch_d  = 1'b0;
        wrap_d      = 1'b0;
        if (valid) begin
            prev_d = count;
            wrap_d = (state != IDLE) && (count < prev);
            case (state)
                IDLE: begin
                    state_d = FIRST;
                end
                FIRST: begin
                    cand_d      = delta;
                    match_cnt_d = CW'(1);
                    state_d     = ACQ;
                end
                ACQ: begin
                    if (delta == cand) begin
                        match_cnt_d = match_inc;
                        if (match_inc == CW'(LOCK_COUNT)) begin
                            incr_d   = cand;
                            locked_d = 1'b1;
                            state_d  = LOCKED;
                        end
                    end else begin
                        cand_d      = delta;
                        match_cnt_d = CW'(1);
                    end
                end
                LOCKED: begin
                    // incr_out deliberately keeps the old step until a relock.
                    if (delta != incr_out) begin
                        mismatch_d  = 1'b1;
                        locked_d    = 1'b0;
                        cand_d      = delta;
                        match_cnt_d = CW'(1);
                        state_d     = ACQ;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prev      <= '0;
            cand      <= '0;
            match_cnt <= '0;
            incr_out  <= '0;
            locked    <= 1'b0;
            mismatch  <= 1'b0;
            wrap      <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            prev      <= '0;
            cand      <= '0;
            match_cnt <= '0;
            incr_out  <= '0;
            locked    <= 1'b0;
            mismatch  <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_d;
            prev      <= prev_d;
            cand      <= cand_d;
            match_cnt <= match_cnt_d;
            incr_out  <= incr_d;
            locked    <= locked_d;
            mismatch  <= mismatch_d;
            wrap      <= wrap_d;
        end
    end

endmodule

// File: tb/tb_incr_recover.sv
// Directed table-driven bench for incr_recover: lock, step change, wrap,
// gapped strobes, clear and asynchronous reset.
module tb_incr_recover;
    import sig_pkg::*;

    localparam int W  = 8;
    localparam int EW = 2 + W + 3;

    typedef struct {
        logic         valid;
        logic         clear;
        logic [W-1:0] count;
        logic [1:0]   exp_state;
        logic [W-1:0] exp_incr;
        logic         exp_locked;
        logic         exp_mismatch;
        logic         exp_wrap;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         valid;
    logic [W-1:0] count;
    logic [W-1:0] incr_out;
    logic         locked;
    logic         mismatch;
    logic         wrap;
    state_t       state_dbg;

    int tests  = 0;
    int errors = 0;

    vec_t         vecs[$];
    logic [EW-1:0] exp_q[$];

    incr_recover dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .valid     (valid),
        .count     (count),
        .incr_out  (incr_out),
        .locked    (locked),
        .mismatch  (mismatch),
        .wrap      (wrap),
        .state_dbg (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, tests=%0d errors=%0d", tests, errors);
        $fatal(1, "watchdog");
    end

    // driver tasks
    function automatic vec_t mk(input logic v, input logic c, input int cnt,
                                input state_t st, input int inc,
                                input logic lk, input logic mm, input logic wr);
        vec_t r;
        r.valid        = v;
        r.clear        = c;
        r.count        = W'(cnt);
        r.exp_state    = st;
        r.exp_incr     = W'(inc);
        r.exp_locked   = lk;
        r.exp_mismatch = mm;
        r.exp_wrap     = wr;
        return r;
    endfunction

    task automatic drive(input logic v, input logic c, input logic [W-1:0] cnt);
        @(negedge clk);
        valid = v;
        clear = c;
        count = cnt;
        @(posedge clk);
        #1;
    endtask

    // scoreboard
    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL %s: scoreboard queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".state"},    int'(state_dbg), int'(e[EW-1 -: 2]));
            check({tag, ".incr"},     int'(incr_out),  int'(e[W+2:3]));
            check({tag, ".locked"},   int'(locked),    int'(e[2]));
            check({tag, ".mismatch"}, int'(mismatch),  int'(e[1]));
            check({tag, ".wrap"},     int'(wrap),      int'(e[0]));
        end
    endtask

    task automatic expect_out(input state_t st, input int inc,
                              input logic lk, input logic mm, input logic wr);
        exp_q.push_back({st, W'(inc), lk, mm, wr});
    endtask

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        valid = 1'b0;
        count = '0;

        // Step 3 from 0, then a step change to 5 with one idle cycle.
        vecs.push_back(mk(1, 0,   0, FIRST,  0, 0, 0, 0));
        vecs.push_back(mk(1, 0,   3, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0,   6, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0,   9, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0,  12, LOCKED, 3, 1, 0, 0));
        vecs.push_back(mk(1, 0,  17, ACQ,    3, 0, 1, 0));
        vecs.push_back(mk(0, 0,   0, ACQ,    3, 0, 0, 0));
        vecs.push_back(mk(1, 0,  22, ACQ,    3, 0, 0, 0));
        vecs.push_back(mk(1, 0,  27, ACQ,    3, 0, 0, 0));
        vecs.push_back(mk(1, 0,  32, LOCKED, 5, 1, 0, 0));
        // Clear, then lock at 10 and wrap 250 -> 4.
        vecs.push_back(mk(1, 1,  99, IDLE,   0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 200, FIRST,  0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 210, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 220, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 230, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 240, LOCKED, 10, 1, 0, 0));
        vecs.push_back(mk(1, 0, 250, LOCKED, 10, 1, 0, 0));
        vecs.push_back(mk(1, 0,   4, LOCKED, 10, 1, 0, 1));
        vecs.push_back(mk(0, 0,   0, LOCKED, 10, 1, 0, 0));
        vecs.push_back(mk(1, 0,  14, LOCKED, 10, 1, 0, 0));
        // clear with valid while locked: the sample is dropped, no wrap after.
        vecs.push_back(mk(1, 1,   0, IDLE,   0, 0, 0, 0));
        vecs.push_back(mk(1, 0,   2, FIRST,  0, 0, 0, 0));
        // Step 7 with two idle cycles between samples.
        vecs.push_back(mk(0, 0,   0, FIRST,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,   0, FIRST,  0, 0, 0, 0));
        vecs.push_back(mk(1, 0,   9, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(0, 0,   0, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(0, 0,   0, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0,  16, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(0, 0,   0, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(0, 0,   0, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0,  23, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(0, 0,   0, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(0, 0,   0, ACQ,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0,  30, LOCKED, 7, 1, 0, 0));
        // Break lock and get to mid-ACQ with two matches counted.
        vecs.push_back(mk(1, 0,  50, ACQ,    7, 0, 1, 0));
        vecs.push_back(mk(1, 0,  60, ACQ,    7, 0, 0, 0));
        vecs.push_back(mk(1, 0,  70, ACQ,    7, 0, 0, 0));

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_out(IDLE, 0, 0, 0, 0);
        check_all("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            expect_out(state_t'(vecs[i].exp_state), int'(vecs[i].exp_incr),
                       vecs[i].exp_locked, vecs[i].exp_mismatch, vecs[i].exp_wrap);
            drive(vecs[i].valid, vecs[i].clear, vecs[i].count);
            check_all($sformatf("vec%0d", i));
        end

        // Asynchronous reset between edges clears outputs immediately.
        @(negedge clk);
        valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        expect_out(IDLE, 0, 0, 0, 0);
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // After reset, counts 100.. need five samples to lock on step 1.
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      expect_out(FIRST,  0, 0, 0, 0);
            else if (i < 4)  expect_out(ACQ,    0, 0, 0, 0);
            else             expect_out(LOCKED, 1, 1, 0, 0);
            drive(1'b1, 1'b0, W'(100 + i));
            check_all($sformatf("relock%0d", i));
        end

        // Steady lock, then an idle cycle keeps everything.
        expect_out(LOCKED, 1, 1, 0, 0);
        drive(1'b1, 1'b0, W'(105));
        check_all("hold_locked");
        expect_out(LOCKED, 1, 1, 0, 0);
        drive(1'b0, 1'b0, W'(0));
        check_all("hold_idle");

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/incr_recover.md
Name: incr_recover

Overview:
- Receive-side counterpart to the signal generator's phase/address counter.
- Observes a sampled count stream and recovers the per-step increment, i.e. the counter's `incr` input.
- Declares lock after a run of consistent deltas, and flags step changes and modular wrap-around.
- Sits on the measurement/self-check path beside the sine ROM address bus, so the generator's frequency setting can be read back and verified.

Parameters:
- WIDTH, 8, width of the observed count and of the recovered increment.
- LOCK_COUNT, 4, consecutive equal deltas needed to declare lock; legal range 2..15.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- clear  input  1  synchronous restart of acquisition; behaves like reset but is applied on the clock edge.
- valid  input  1  sample strobe; tie to the counter's enable so each strobe is one counter step.
- count  input  WIDTH  observed counter value, sampled when valid=1.
- incr_out  output  WIDTH  recovered increment; holds the last locked value.
- locked  output  1  high while the recovered increment is trusted.
- mismatch  output  1  one-cycle pulse when a delta disagrees with incr_out while locked.
- wrap  output  1  one-cycle pulse when a sample is unsigned-less-than the previous sample.

Behaviour:
- Reset (rst high, asynchronous):
  - state=IDLE, prev=0, cand=0, match_cnt=0.
  - incr_out=0, locked=0, mismatch=0, wrap=0.
- clear=1 at an edge: same values as reset. clear wins over a simultaneous valid, and that sample is discarded.
- All outputs are registered. Effects of a sample taken at edge N are visible after edge N.
- delta = (count - prev) mod 2^WIDTH, with WIDTH-bit wrap and no carry out. delta=0 is legal (increment 0).
- prev <= count on every accepted valid, in all states.
- mismatch and wrap default to 0 every cycle and are asserted only on a sample edge.
- wrap=1 on an accepted sample when state != IDLE and count < prev (unsigned).
- States: IDLE, FIRST, ACQ, LOCKED. valid=0 means no state change and pulses return to 0.
  - IDLE, valid: go to FIRST. No delta is computed.
  - FIRST, valid: cand <= delta, match_cnt <= 1, go to ACQ.
  - ACQ, valid, delta==cand:
    - match_cnt <= match_cnt+1.
    - If match_cnt+1 == LOCK_COUNT: incr_out <= cand, locked <= 1, go to LOCKED.
  - ACQ, valid, delta!=cand: cand <= delta, match_cnt <= 1, stay in ACQ.
  - LOCKED, valid, delta==incr_out: stay in LOCKED with no output change.
  - LOCKED, valid, delta!=incr_out:
    - mismatch <= 1, locked <= 0.
    - cand <= delta, match_cnt <= 1, go to ACQ.
    - incr_out holds its old value.
- match_cnt is ceil(log2(LOCK_COUNT+1)) bits wide and never exceeds LOCK_COUNT.
- Lock latency from the first sample with valid every cycle: LOCK_COUNT+1 samples. locked rises at the edge that accepts sample LOCK_COUNT (0-indexed).
- A gap in valid does not break acquisition; deltas are computed between consecutive accepted samples.
- Reset mid-operation discards all history. The next valid is treated as a first sample.

Decomposition:
- Shared package sig_pkg holds:
  - the state enum (IDLE, FIRST, ACQ, LOCKED);
  - the default WIDTH constant, shared with the counter;
  - the default LOCK_COUNT.
- No sub-module is needed. The modular subtractor and comparator stay inline; a single FSM plus datapath registers.

Test Plan:
- Step 3 from 0 (counts 0,3,6,9,12) with valid every cycle -> locked=1 after the 5th sample edge, incr_out=3; mismatch and wrap stay 0.
- Wrap: locked with incr 10, counts 240,250,4 -> wrap=1 for exactly one cycle on sample 4; locked stays 1, incr_out=10, no mismatch.
- Step change: locked at 3, counts ...,12,17,22,27,32 -> mismatch pulse and locked=0 on 17; relock at 32 with incr_out=5. incr_out reads 3 until the relock.
- Gapped valid: step 7 with valid low 2 cycles between samples -> lock after 5 samples, incr_out=7; no pulses while valid=0.
- rst asserted asynchronously mid-ACQ (match_cnt=2) -> outputs 0 immediately. After release, counts 100,101,... need 5 samples to lock with incr_out=1.
- clear and valid high together while locked -> state IDLE, locked=0, that sample is ignored, and the next sample produces no wrap.
